// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Purpose : Shared definitions for the Morse key front end. Holds the 2-bit
//           symbol codes (also used by morse_decoder), the classifier FSM
//           state encoding and the synchronizer depth.
// Ports   : none (package)
// Config  : MORSE_KEY_DEBOUNCE_EN is consumed by morse_key_debouncer, not here.
// -----------------------------------------------------------------------------
package morse_pkg;

    // Symbol codes seen on the decoder's in[1:0] input.
    typedef enum logic [1:0] {
        SYM_GAP    = 2'b00,
        SYM_DOT    = 2'b01,
        SYM_TWOGAP = 2'b10,
        SYM_DASH   = 2'b11
    } sym_t;

    // Classifier FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PRESS    = 2'b01,
        GAPWAIT  = 2'b10,
        WORDWAIT = 2'b11
    } state_t;

    // Flops between the asynchronous key pin and the first use of its level.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/morse_key_debouncer.sv
// -----------------------------------------------------------------------------
// morse_key_debouncer
// Purpose : Brings the raw key level into the clk domain through a 2-flop
//           synchronizer and, when MORSE_KEY_DEBOUNCE_EN is defined, accepts a
//           level change only after it has been stable for DEBOUNCE_CYC
//           consecutive cycles. Without the macro key_db is the synchronizer
//           output directly.
// Ports   : clk      in  system clock
//           rst      in  synchronous active-high reset
//           key      in  raw key level (asynchronous, 1 = pressed)
//           key_db   out conditioned key level
//           settled  out key_db reflects the real key (pipeline flushed since
//                        reset and no debounce decision pending)
// Config  : MORSE_KEY_DEBOUNCE_EN enables the debounce filter.
// -----------------------------------------------------------------------------
module morse_key_debouncer
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_db,
    output logic settled
);

    if (DEBOUNCE_CYC < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYC must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [1:0]             flush_reg;
    logic                   flush_done;
    logic                   sync_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], key};
        end
    end

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // After reset the synchronizer still holds reset zeros; the level is only
    // trustworthy once every stage has been reloaded from the pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_reg <= '0;
        end else if (!flush_done) begin
            flush_reg <= flush_reg + 2'd1;
        end
    end

    assign flush_done = (flush_reg == 2'(SYNC_STAGES));

`ifdef MORSE_KEY_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] db_cnt_reg;
    logic             key_db_reg;

    // Count consecutive cycles where the synchronized level disagrees with the
    // accepted level; any agreement restarts the count, so short glitches die.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_reg <= '0;
            key_db_reg <= 1'b0;
        end else if (sync_out == key_db_reg) begin
            db_cnt_reg <= '0;
        end else if (db_cnt_reg == CNT_LAST) begin
            db_cnt_reg <= '0;
            key_db_reg <= sync_out;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    assign key_db  = key_db_reg;
    assign settled = flush_done && (sync_out == key_db_reg);
`else
    assign key_db  = sync_out;
    assign settled = flush_done;
`endif

endmodule

// File: rtl/morse_key_classifier.sv
// -----------------------------------------------------------------------------
// morse_key_classifier
// Purpose : Turns the Morse key level into DOT/DASH/GAP/TWOGAP symbol strobes
//           for morse_decoder. Key-down and key-up times are measured in Morse
//           units by a prescaler plus a saturating unit counter, both cleared
//           on every conditioned key edge.
// Ports   : clk        in  system clock
//           rst        in  synchronous active-high reset
//           key        in  raw key level (asynchronous, 1 = pressed)
//           sym[1:0]   out symbol code, DOT=01 DASH=11 GAP=00 TWOGAP=10
//           sym_valid  out one-cycle strobe qualifying sym
//           key_db     out conditioned key level
// Config  : MORSE_KEY_DEBOUNCE_EN enables the debounce filter in
//           morse_key_debouncer; otherwise key_db is the synchronized key.
// -----------------------------------------------------------------------------
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int CLK_PER_UNIT     = 50000,
    parameter int DASH_MIN_UNITS   = 2,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7,
    parameter int DEBOUNCE_CYC     = 1000,
    parameter int UNIT_W           = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic [1:0] sym,
    output logic       sym_valid,
    output logic       key_db
);

    if (CLK_PER_UNIT < 2) begin : g_bad_clk_per_unit
        $error("CLK_PER_UNIT must be at least 2");
    end
    if (WORD_GAP_UNITS <= LETTER_GAP_UNITS) begin : g_bad_gap_order
        $error("WORD_GAP_UNITS must exceed LETTER_GAP_UNITS");
    end
    if (WORD_GAP_UNITS > (2 ** UNIT_W) - 1) begin : g_bad_unit_w
        $error("UNIT_W too narrow to reach WORD_GAP_UNITS");
    end

    localparam int PRE_W = $clog2(CLK_PER_UNIT);
    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(CLK_PER_UNIT - 1);
    localparam logic [PRE_W-1:0]  PRE_FIRST   = PRE_W'(1);
    localparam logic [UNIT_W-1:0] DASH_MIN    = UNIT_W'(DASH_MIN_UNITS);
    localparam logic [UNIT_W-1:0] LETTER_LAST = UNIT_W'(LETTER_GAP_UNITS - 1);
    localparam logic [UNIT_W-1:0] WORD_LAST   = UNIT_W'(WORD_GAP_UNITS - 1);
    localparam logic [UNIT_W-1:0] UNIT_MAX    = '1;

    logic              key_db_int;
    logic              settled;
    logic              key_db_prev_reg;
    logic              armed_reg;
    logic              rise;
    logic              fall;
    logic              key_edge;
    logic              unit_tick;
    logic              letter_reach;
    logic              word_reach;
    logic [PRE_W-1:0]  pre_reg, pre_next;
    logic [UNIT_W-1:0] unit_cnt_reg, unit_cnt_next;
    state_t            state_reg, state_next;
    sym_t              sym_reg, sym_next;
    logic              sym_valid_reg, sym_valid_next;

    morse_key_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debouncer (
        .clk     (clk),
        .rst     (rst),
        .key     (key),
        .key_db  (key_db_int),
        .settled (settled)
    );

    assign rise     = key_db_int && !key_db_prev_reg;
    assign fall     = !key_db_int && key_db_prev_reg;
    assign key_edge = rise || fall;

    // The edge cycle itself is count 0 of the new interval, so the prescaler
    // restarts at 1; an N-unit interval then spans exactly N*CLK_PER_UNIT
    // cycles of key_db level.
    assign unit_tick = (pre_reg == PRE_LAST);

    always_comb begin
        pre_next = pre_reg + 1'b1;
        if (key_edge) begin
            pre_next = PRE_FIRST;
        end else if (unit_tick) begin
            pre_next = '0;
        end
    end

    always_comb begin
        unit_cnt_next = unit_cnt_reg;
        if (key_edge) begin
            unit_cnt_next = '0;
        end else if (unit_tick && (unit_cnt_reg != UNIT_MAX)) begin
            unit_cnt_next = unit_cnt_reg + 1'b1;
        end
    end

    // Threshold detection looks at the tick that completes the unit rather
    // than the cleared count, so a key edge in the same cycle cannot hide it.
    assign letter_reach = unit_tick && (unit_cnt_reg == LETTER_LAST);
    assign word_reach   = unit_tick && (unit_cnt_reg == WORD_LAST);

    always_comb begin
        state_next     = state_reg;
        sym_next       = sym_reg;
        sym_valid_next = 1'b0;
        case (state_reg)
            IDLE: begin
                // armed_reg blocks a key that was already held through reset.
                if (rise && armed_reg) begin
                    state_next = PRESS;
                end
            end
            PRESS: begin
                if (fall) begin
                    sym_next       = (unit_cnt_reg >= DASH_MIN) ? SYM_DASH : SYM_DOT;
                    sym_valid_next = 1'b1;
                    state_next     = GAPWAIT;
                end
            end
            GAPWAIT: begin
                if (letter_reach) begin
                    sym_next       = SYM_GAP;
                    sym_valid_next = 1'b1;
                    state_next     = rise ? PRESS : WORDWAIT;
                end else if (rise) begin
                    state_next = PRESS;
                end
            end
            WORDWAIT: begin
                if (word_reach) begin
                    sym_next       = SYM_TWOGAP;
                    sym_valid_next = 1'b1;
                    state_next     = rise ? PRESS : IDLE;
                end else if (rise) begin
                    state_next = PRESS;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_db_prev_reg <= 1'b0;
            armed_reg       <= 1'b0;
            pre_reg         <= '0;
            unit_cnt_reg    <= '0;
            state_reg       <= IDLE;
            sym_reg         <= SYM_GAP;
            sym_valid_reg   <= 1'b0;
        end else begin
            key_db_prev_reg <= key_db_int;
            if (settled && !key_db_int) begin
                armed_reg <= 1'b1;
            end
            pre_reg         <= pre_next;
            unit_cnt_reg    <= unit_cnt_next;
            state_reg       <= state_next;
            sym_reg         <= sym_next;
            sym_valid_reg   <= sym_valid_next;
        end
    end

    assign sym       = sym_reg;
    assign sym_valid = sym_valid_reg;
    assign key_db    = key_db_int;

endmodule

// File: tb/tb_morse_key_classifier.sv
// -----------------------------------------------------------------------------
// tb_morse_key_classifier
// Purpose : Directed self-checking bench for morse_key_classifier with
//           CLK_PER_UNIT=4 and DEBOUNCE_CYC=3. Strobes are captured with their
//           cycle number and compared against hand-computed symbol sequences
//           and timings. Build with or without MORSE_KEY_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
module tb_morse_key_classifier;

    localparam int CPU = 4;
    localparam int DEB = 3;
`ifdef MORSE_KEY_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;   // key pin to key_db level change
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        logic [1:0] s;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       key;
    logic [1:0] sym;
    logic       sym_valid;
    logic       key_db;

    int  cyc;
    int  n_checks;
    int  n_fail;
    bit  db_seen;
    ev_t ev_q[$];

    morse_key_classifier #(
        .CLK_PER_UNIT     (CPU),
        .DASH_MIN_UNITS   (2),
        .LETTER_GAP_UNITS (3),
        .WORD_GAP_UNITS   (7),
        .DEBOUNCE_CYC     (DEB),
        .UNIT_W           (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .sym       (sym),
        .sym_valid (sym_valid),
        .key_db    (key_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sym_valid === 1'b1) begin
            ev_t e;
            e.s   = sym;
            e.cyc = cyc;
            ev_q.push_back(e);
            $display("[%0d] strobe sym=%b", cyc, sym);
        end
        if (key_db === 1'b1) db_seen = 1'b1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key = 1'b1;
        step(2);
        n_checks++;
        if (sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", sym_valid);
        end
        n_checks++;
        if (sym !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_sym: got %b want 00", sym);
        end
        n_checks++;
        if (key_db !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_key_db: got %b want 0", key_db);
        end
        rst = 1'b0;
        ev_q.delete();
        step(40);
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_after_reset: got %0d strobes want 0", ev_q.size());
        end
        n_checks++;
        if (key_db !== 1'b1) begin
            n_fail++;
            $display("FAIL held_key_db: got %b want 1", key_db);
        end
        key = 1'b0;
        step(40);
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL release_after_reset: got %0d strobes want 0", ev_q.size());
        end
        $display("test_reset done");
    endtask

    task automatic test_short_press();
        int c;
        int e;
        logic [1:0] exp_s[3];
        int exp_c[3];
        ev_q.delete();
        c = cyc;
        key = 1'b1;
        step(4);
        key = 1'b0;
        step(40);
        e = c + 4 + LAT;
        exp_s = '{2'b01, 2'b00, 2'b10};
        exp_c = '{e + 1, e + 12, e + 28};
        n_checks++;
        if (ev_q.size() != 3) begin
            n_fail++;
            $display("FAIL short_count: got %0d want 3", ev_q.size());
        end
        for (int i = 0; i < 3 && i < ev_q.size(); i++) begin
            n_checks++;
            if (ev_q[i].s !== exp_s[i] || ev_q[i].cyc != exp_c[i]) begin
                n_fail++;
                $display("FAIL short_ev%0d: got %b@%0d want %b@%0d",
                         i, ev_q[i].s, ev_q[i].cyc, exp_s[i], exp_c[i]);
            end
        end
        n_checks++;
        if (sym !== 2'b10 || sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sym_hold: got sym=%b valid=%b want sym=10 valid=0", sym, sym_valid);
        end
        $display("test_short_press done");
    endtask

    task automatic test_dash();
        int durs[3];
        logic [1:0] exps[3];
        int c;
        durs = '{8, 7, 80};
        exps = '{2'b11, 2'b01, 2'b11};
        for (int k = 0; k < 3; k++) begin
            ev_q.delete();
            c = cyc;
            key = 1'b1;
            step(durs[k]);
            key = 1'b0;
            step(40);
            n_checks++;
            if (ev_q.size() != 3) begin
                n_fail++;
                $display("FAIL press%0d_count: got %0d want 3", durs[k], ev_q.size());
            end else if (ev_q[0].s !== exps[k] || ev_q[0].cyc != c + durs[k] + LAT + 1) begin
                n_fail++;
                $display("FAIL press%0d_sym: got %b@%0d want %b@%0d", durs[k],
                         ev_q[0].s, ev_q[0].cyc, exps[k], c + durs[k] + LAT + 1);
            end
            $display("press %0d cycles -> %0d strobes", durs[k], ev_q.size());
        end
    endtask

    task automatic test_letter_a();
        int c;
        int e2;
        logic [1:0] exp_s[4];
        int exp_c[4];
        ev_q.delete();
        c = cyc;
        key = 1'b1;
        step(4);
        key = 1'b0;
        step(4);
        key = 1'b1;
        step(8);
        key = 1'b0;
        step(40);
        e2 = c + 16 + LAT;
        exp_s = '{2'b01, 2'b11, 2'b00, 2'b10};
        exp_c = '{c + 4 + LAT + 1, e2 + 1, e2 + 12, e2 + 28};
        n_checks++;
        if (ev_q.size() != 4) begin
            n_fail++;
            $display("FAIL letter_a_count: got %0d want 4", ev_q.size());
        end
        for (int i = 0; i < 4 && i < ev_q.size(); i++) begin
            n_checks++;
            if (ev_q[i].s !== exp_s[i] || ev_q[i].cyc != exp_c[i]) begin
                n_fail++;
                $display("FAIL letter_a_ev%0d: got %b@%0d want %b@%0d",
                         i, ev_q[i].s, ev_q[i].cyc, exp_s[i], exp_c[i]);
            end
        end
        $display("test_letter_a done");
    endtask

    task automatic test_bounce();
        ev_q.delete();
        db_seen = 1'b0;
        key = 1'b1;
        step(2);
        key = 1'b0;
        step(40);
`ifdef MORSE_KEY_DEBOUNCE_EN
        n_checks++;
        if (db_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_key_db: got glitch on key_db want none");
        end
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_strobes: got %0d want 0", ev_q.size());
        end
`else
        n_checks++;
        if (db_seen !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_key_db: got no glitch on key_db want one");
        end
        n_checks++;
        if (ev_q.size() != 3) begin
            n_fail++;
            $display("FAIL bounce_strobes: got %0d want 3", ev_q.size());
        end else if (ev_q[0].s !== 2'b01) begin
            n_fail++;
            $display("FAIL bounce_sym: got %b want 01", ev_q[0].s);
        end
`endif
        $display("test_bounce done");
    endtask

    task automatic test_collision();
        int c;
        int e;
        logic [1:0] exp_s[5];
        int exp_c[5];
        ev_q.delete();
        c = cyc;
        key = 1'b1;
        step(4);
        key = 1'b0;
        step(11);        // key_db rises in the cycle the third gap unit completes
        key = 1'b1;
        step(4);
        key = 1'b0;
        step(50);
        e = c + 4 + LAT;
        exp_s = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
        exp_c = '{e + 1, e + 12, e + 16, e + 27, e + 43};
        n_checks++;
        if (ev_q.size() != 5) begin
            n_fail++;
            $display("FAIL collision_count: got %0d want 5", ev_q.size());
        end
        for (int i = 0; i < 5 && i < ev_q.size(); i++) begin
            n_checks++;
            if (ev_q[i].s !== exp_s[i] || ev_q[i].cyc != exp_c[i]) begin
                n_fail++;
                $display("FAIL collision_ev%0d: got %b@%0d want %b@%0d",
                         i, ev_q[i].s, ev_q[i].cyc, exp_s[i], exp_c[i]);
            end
        end
        $display("test_collision done");
    endtask

    task automatic test_reset_mid_press();
        int c;
        ev_q.delete();
        key = 1'b1;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        key = 1'b0;
        step(40);
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_press: got %0d strobes want 0", ev_q.size());
        end
        ev_q.delete();
        c = cyc;
        key = 1'b1;
        step(4);
        key = 1'b0;
        step(40);
        n_checks++;
        if (ev_q.size() != 3) begin
            n_fail++;
            $display("FAIL repress_count: got %0d want 3", ev_q.size());
        end else if (ev_q[0].s !== 2'b01 || ev_q[0].cyc != c + 4 + LAT + 1) begin
            n_fail++;
            $display("FAIL repress_sym: got %b@%0d want 01@%0d",
                     ev_q[0].s, ev_q[0].cyc, c + 4 + LAT + 1);
        end
        $display("test_reset_mid_press done");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        db_seen  = 1'b0;
        rst      = 1'b1;
        key      = 1'b0;
        test_reset();
        test_short_press();
        test_dash();
        test_letter_a();
        test_bounce();
        test_collision();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
